// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit between EX and MEM. Issues data-bus commands,
//             flags misaligned accesses, builds byte lanes, tracks the
//             command/response handshake and formats load results.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_stage_run,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_mem_opcode,
  input  logic [31:0]           ex_address,
  input  logic [31:0]           ex_writedata,
  output logic                  exc_load_addr_misaligned,
  output logic                  exc_store_addr_misaligned,
  output logic                  dbus_read,
  output logic                  dbus_write,
  output logic [ADDR_WIDTH-1:0] dbus_address,
  output logic [3:0]            dbus_byteenable,
  output logic [31:0]           dbus_writedata,
  input  logic                  dbus_waitrequest,
  input  logic [31:0]           dbus_readdata,
  input  logic                  dbus_readdatavalid,
  output logic [31:0]           lsu_readdata,
  output logic                  lsu_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // funct3 encodings
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  state_t                  state_q, state_d;
  logic                    cmd_read_q, cmd_read_d;
  logic                    cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [3:0]              cmd_be_q, cmd_be_d;
  logic [31:0]             cmd_wd_q, cmd_wd_d;
  logic [1:0]              off_q, off_d;
  logic [2:0]              op_q, op_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    misaligned;
  logic                    issue_ok;
  logic                    issue;
  logic                    resp_done;
  logic [ADDR_WIDTH-1:0]   ex_addr_w;
  logic [3:0]              ex_be;
  logic [31:0]             ex_wd;
  logic [31:0]             rd_shift;
  logic [31:0]             rd_fmt;

  // Upper address bits beyond the bus width are simply dropped.
  generate
    if (ADDR_WIDTH < 32) begin : g_addr_trunc
      logic unused_hi;
      assign unused_hi = ^ex_address[31:ADDR_WIDTH];
    end
  endgenerate

  // Decode alignment, lane enables and replicated store data from EX operands.
  always_comb begin
    misaligned = 1'b0;
    ex_be      = 4'b1111;
    ex_wd      = ex_writedata;
    case (ex_mem_opcode[1:0])
      2'b00: begin
        ex_be = 4'b0001 << ex_address[1:0];
        ex_wd = {4{ex_writedata[7:0]}};
      end
      2'b01: begin
        misaligned = ex_address[0];
        ex_be      = 4'b0011 << ex_address[1:0];
        ex_wd      = {2{ex_writedata[15:0]}};
      end
      2'b10: begin
        misaligned = (ex_address[1:0] != 2'b00);
      end
      default: ;
    endcase
    ex_addr_w = {ex_address[ADDR_WIDTH-1:2], 2'b00};

    exc_load_addr_misaligned  = ex_valid & ex_mem_read  & misaligned;
    exc_store_addr_misaligned = ex_valid & ex_mem_write & misaligned;

    resp_done = (state_q == S_RESP) & dbus_readdatavalid;
    issue_ok  = (state_q == S_IDLE) | resp_done;
    issue     = ~rst & ex_valid & ex_stage_run & (ex_mem_read | ex_mem_write)
                & ~misaligned & issue_ok;
  end

  // Drive the bus: latched command while waiting, fresh EX command on issue.
  always_comb begin
    dbus_read       = 1'b0;
    dbus_write      = 1'b0;
    dbus_address    = '0;
    dbus_byteenable = 4'b0000;
    dbus_writedata  = 32'h0;
    if (!rst) begin
      if (state_q == S_CMD) begin
        dbus_read       = cmd_read_q;
        dbus_write      = cmd_write_q;
        dbus_address    = cmd_addr_q;
        dbus_byteenable = cmd_be_q;
        dbus_writedata  = cmd_wd_q;
      end else if (issue) begin
        dbus_read       = ex_mem_read;
        dbus_write      = ~ex_mem_read & ex_mem_write;
        dbus_address    = ex_addr_w;
        dbus_byteenable = ex_be;
        dbus_writedata  = ex_wd;
      end
    end
  end

  // Stall depends only on state and bus handshake, never on EX inputs.
  always_comb begin
    lsu_stall = ~rst & (((state_q == S_CMD) & dbus_waitrequest) |
                        ((state_q == S_RESP) & ~dbus_readdatavalid));
  end

  // Extract and extend the addressed lane of the response using the latched offset/opcode.
  always_comb begin
    rd_shift = dbus_readdata >> {off_q, 3'b000};
    case (op_q)
      OP_B:    rd_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_H:    rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_BU:   rd_fmt = {24'h0, rd_shift[7:0]};
      OP_HU:   rd_fmt = {16'h0, rd_shift[15:0]};
      default: rd_fmt = dbus_readdata;
    endcase
    lsu_readdata = resp_done ? rd_fmt : rdata_q;
  end

  // Next-state, command latch and held-data computation.
  always_comb begin
    state_d     = state_q;
    cmd_read_d  = cmd_read_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_be_d    = cmd_be_q;
    cmd_wd_d    = cmd_wd_q;
    off_d       = off_q;
    op_d        = op_q;
    rdata_d     = resp_done ? rd_fmt : rdata_q;

    if (issue) begin
      off_d = ex_address[1:0];
      op_d  = ex_mem_opcode;
      if (dbus_waitrequest) begin
        state_d     = S_CMD;
        cmd_read_d  = ex_mem_read;
        cmd_write_d = ~ex_mem_read & ex_mem_write;
        cmd_addr_d  = ex_addr_w;
        cmd_be_d    = ex_be;
        cmd_wd_d    = ex_wd;
      end else begin
        state_d = ex_mem_read ? S_RESP : S_IDLE;
      end
    end else begin
      case (state_q)
        S_CMD:   if (!dbus_waitrequest) state_d = cmd_read_q ? S_RESP : S_IDLE;
        S_RESP:  if (dbus_readdatavalid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_be_q    <= 4'b0000;
      cmd_wd_q    <= 32'h0;
      off_q       <= 2'b00;
      op_q        <= 3'b000;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cmd_read_q  <= cmd_read_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_be_q    <= cmd_be_d;
      cmd_wd_q    <= cmd_wd_d;
      off_q       <= off_d;
      op_q        <= op_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Directed self-checking bench for the load/store unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stage_run, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_mem_opcode;
  logic [31:0] ex_address, ex_writedata;
  logic        exc_load_addr_misaligned, exc_store_addr_misaligned;
  logic        dbus_read, dbus_write;
  logic [31:0] dbus_address;
  logic [3:0]  dbus_byteenable;
  logic [31:0] dbus_writedata;
  logic        dbus_waitrequest;
  logic [31:0] dbus_readdata;
  logic        dbus_readdatavalid;
  logic [31:0] lsu_readdata;
  logic        lsu_stall;

  int n_cmp = 0;
  int n_err = 0;

  lsu #(.ADDR_WIDTH(32)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .ex_valid                  (ex_valid),
    .ex_stage_run              (ex_stage_run),
    .ex_mem_read               (ex_mem_read),
    .ex_mem_write              (ex_mem_write),
    .ex_mem_opcode             (ex_mem_opcode),
    .ex_address                (ex_address),
    .ex_writedata              (ex_writedata),
    .exc_load_addr_misaligned  (exc_load_addr_misaligned),
    .exc_store_addr_misaligned (exc_store_addr_misaligned),
    .dbus_read                 (dbus_read),
    .dbus_write                (dbus_write),
    .dbus_address              (dbus_address),
    .dbus_byteenable           (dbus_byteenable),
    .dbus_writedata            (dbus_writedata),
    .dbus_waitrequest          (dbus_waitrequest),
    .dbus_readdata             (dbus_readdata),
    .dbus_readdatavalid        (dbus_readdatavalid),
    .lsu_readdata              (lsu_readdata),
    .lsu_stall                 (lsu_stall)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point mid-cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic ex_clear();
    ex_valid      = 1'b0;
    ex_stage_run  = 1'b1;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_mem_opcode = 3'b000;
    ex_address    = 32'h0;
    ex_writedata  = 32'h0;
  endtask

  task automatic ex_op(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, input logic run);
    ex_valid      = 1'b1;
    ex_stage_run  = run;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_mem_opcode = op;
    ex_address    = addr;
    ex_writedata  = wd;
  endtask

  initial begin
    rst                = 1'b1;
    dbus_waitrequest   = 1'b0;
    dbus_readdata      = 32'h0;
    dbus_readdatavalid = 1'b0;
    ex_clear();

    // Reset state
    step(); step();
    sample();
    check("rst_read",  {31'h0, dbus_read}, 32'h0);
    check("rst_stall", {31'h0, lsu_stall}, 32'h0);
    check("rst_rdata", lsu_readdata, 32'h0);
    step();
    rst = 1'b0;

    // 1. LW 0x100, one-cycle sync RAM
    ex_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b1);
    sample();
    check("t1_read",  {31'h0, dbus_read}, 32'h1);
    check("t1_be",    {28'h0, dbus_byteenable}, 32'hF);
    check("t1_addr",  dbus_address, 32'h0000_0100);
    check("t1_stall0", {31'h0, lsu_stall}, 32'h0);
    step();
    ex_clear();
    dbus_readdatavalid = 1'b1; dbus_readdata = 32'h8899_AABB;
    sample();
    check("t1_read_off", {31'h0, dbus_read}, 32'h0);
    check("t1_rdata",    lsu_readdata, 32'h8899_AABB);
    check("t1_stall1",   {31'h0, lsu_stall}, 32'h0);
    step();
    dbus_readdatavalid = 1'b0; dbus_readdata = 32'h0;
    sample();
    check("t1_hold", lsu_readdata, 32'h8899_AABB);

    // 2. LB 0x103 then LBU 0x103 back-to-back
    step();
    ex_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1);
    sample();
    check("t2_be",   {28'h0, dbus_byteenable}, 32'h8);
    check("t2_addr", dbus_address, 32'h0000_0100);
    step();
    ex_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1'b1);
    dbus_readdatavalid = 1'b1; dbus_readdata = 32'h80FF_0000;
    sample();
    check("t2_lb",       lsu_readdata, 32'hFFFF_FF80);
    check("t2_lbu_read", {31'h0, dbus_read}, 32'h1);
    check("t2_stall",    {31'h0, lsu_stall}, 32'h0);
    step();
    ex_clear();
    sample();
    check("t2_lbu", lsu_readdata, 32'h0000_0080);
    step();
    dbus_readdatavalid = 1'b0; dbus_readdata = 32'h0;

    // 3. SH 0x102 with waitrequest held in the issue cycle and three CMD cycles
    ex_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1'b1);
    dbus_waitrequest = 1'b1;
    sample();
    check("t3_wr_issue", {31'h0, dbus_write}, 32'h1);
    check("t3_be",       {28'h0, dbus_byteenable}, 32'hC);
    check("t3_wd",       dbus_writedata, 32'h1234_1234);
    check("t3_stall_i",  {31'h0, lsu_stall}, 32'h0);
    step();
    // EX now holds an unrelated load that must not disturb the latched store
    ex_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("t3_wr_c%0d", i),    {31'h0, dbus_write}, 32'h1);
      check($sformatf("t3_rd_c%0d", i),    {31'h0, dbus_read}, 32'h0);
      check($sformatf("t3_addr_c%0d", i),  dbus_address, 32'h0000_0100);
      check($sformatf("t3_be_c%0d", i),    {28'h0, dbus_byteenable}, 32'hC);
      check($sformatf("t3_wd_c%0d", i),    dbus_writedata, 32'h1234_1234);
      check($sformatf("t3_stall_c%0d", i), {31'h0, lsu_stall}, 32'h1);
      step();
    end
    dbus_waitrequest = 1'b0;
    sample();
    check("t3_wr_acc",    {31'h0, dbus_write}, 32'h1);
    check("t3_wd_acc",    dbus_writedata, 32'h1234_1234);
    check("t3_stall_acc", {31'h0, lsu_stall}, 32'h0);
    step();
    sample();
    check("t3_idle_wr",    {31'h0, dbus_write}, 32'h0);
    check("t3_idle_rd",    {31'h0, dbus_read}, 32'h0);
    check("t3_idle_stall", {31'h0, lsu_stall}, 32'h0);
    step();

    // 4. Misaligned LW 0x101 and SH 0x003
    ex_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1'b1);
    sample();
    check("t4_lmis",   {31'h0, exc_load_addr_misaligned}, 32'h1);
    check("t4_smis_0", {31'h0, exc_store_addr_misaligned}, 32'h0);
    check("t4_lw_rd",  {31'h0, dbus_read}, 32'h0);
    step();
    ex_op(1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h0000_ABCD, 1'b1);
    sample();
    check("t4_smis",   {31'h0, exc_store_addr_misaligned}, 32'h1);
    check("t4_lmis_0", {31'h0, exc_load_addr_misaligned}, 32'h0);
    check("t4_sh_wr",  {31'h0, dbus_write}, 32'h0);
    step();
    ex_clear();
    sample();
    check("t4_stall", {31'h0, lsu_stall}, 32'h0);
    step();

    // 5. Back-to-back loads, first response delayed two cycles
    ex_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b1);
    sample();
    check("t5_a_read", {31'h0, dbus_read}, 32'h1);
    step();
    ex_op(1'b1, 1'b0, 3'b001, 32'h0000_0306, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sample();
      check($sformatf("t5_stall_w%0d", i), {31'h0, lsu_stall}, 32'h1);
      check($sformatf("t5_rd_w%0d", i),    {31'h0, dbus_read}, 32'h0);
      step();
    end
    ex_stage_run = 1'b1;
    dbus_readdatavalid = 1'b1; dbus_readdata = 32'hDEAD_BEEF;
    sample();
    check("t5_stall_r", {31'h0, lsu_stall}, 32'h0);
    check("t5_a_data",  lsu_readdata, 32'hDEAD_BEEF);
    check("t5_b_read",  {31'h0, dbus_read}, 32'h1);
    check("t5_b_addr",  dbus_address, 32'h0000_0304);
    check("t5_b_be",    {28'h0, dbus_byteenable}, 32'hC);
    step();
    ex_clear();
    dbus_readdata = 32'h8001_1234;
    sample();
    check("t5_b_data",  lsu_readdata, 32'hFFFF_8001);
    check("t5_stall_b", {31'h0, lsu_stall}, 32'h0);
    step();
    dbus_readdatavalid = 1'b0; dbus_readdata = 32'h0;
    sample();
    check("t5_b_hold", lsu_readdata, 32'hFFFF_8001);
    step();

    // 6. Reset while waiting for a response; late response ignored
    ex_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 1'b1);
    step();
    ex_clear();
    sample();
    check("t6_resp_stall", {31'h0, lsu_stall}, 32'h1);
    step();
    rst = 1'b1;
    sample();
    check("t6_rst_stall", {31'h0, lsu_stall}, 32'h0);
    check("t6_rst_read",  {31'h0, dbus_read}, 32'h0);
    step();
    rst = 1'b0;
    dbus_readdatavalid = 1'b1; dbus_readdata = 32'h5555_5555;
    sample();
    check("t6_stray_data",  lsu_readdata, 32'h0);
    check("t6_stray_stall", {31'h0, lsu_stall}, 32'h0);
    check("t6_stray_read",  {31'h0, dbus_read}, 32'h0);
    step();
    dbus_readdatavalid = 1'b0; dbus_readdata = 32'h0;
    sample();
    check("t6_hold", lsu_readdata, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
